// File: rtl/arb_rr_4input.sv
// -----------------------------------------------------------------------------
// arb_rr_4input
//
// Four-requester round-robin arbiter with grant hold. A requester that wins
// keeps the resource for as long as its request stays high; when it lets go,
// the grant drops for at least one cycle before the next winner is chosen.
// The search for the next winner starts just past the most recent winner, so
// every active requester is served in turn.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, an owner is forced off after MAX_HOLD consecutive granted
//   cycles. The revocation raises a one-cycle timeout pulse and masks that
//   requester until it lowers its request. When undefined, there is no hold
//   counter and no mask, timeout is tied low and grants are held
//   indefinitely.
//
// Parameters:
//   MAX_HOLD  maximum consecutive granted cycles (2..255), ARB_TIMEOUT_EN only
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     synchronous active-low reset (0 = reset asserted)
//   req       request lines, bit i = requester i wants or holds the resource
//   grant     registered one-hot (or all-zero) grant
//   grant_id  registered index of the current or most recent grant holder
//   busy      registered, high exactly when grant is nonzero
//   timeout   registered one-cycle pulse when a grant is revoked by the limit
// -----------------------------------------------------------------------------
module arb_rr_4input #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    // Reject out-of-range configurations at elaboration time.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arb_rr_4input: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e     state_q,    state_d;
    logic [3:0] grant_q,    grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       busy_q,     busy_d;
    logic [1:0] ptr_q,      ptr_d;

`ifdef ARB_TIMEOUT_EN
    logic       timeout_q,  timeout_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] mask_q,     mask_d;
`endif

    // Requests allowed to compete in IDLE.
    logic [3:0] eligible;
    logic       pick_valid;
    logic [1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
    assign eligible = req & ~mask_q;
`else
    assign eligible = req;
`endif

    // -------------------------------------------------------------------------
    // Round-robin search: first set bit of vec visiting ptr, ptr+1, ... with
    // 2-bit wraparound. The found flag keeps the earliest hit in that order.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [1:0] idx;
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
`ifdef ARB_TIMEOUT_EN
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        // A mask bit lasts only while its request stays high.
        mask_d     = mask_q & req;
`endif

        unique case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                if (pick_valid) begin
                    grant_d    = 4'b0001 << pick_idx;
                    grant_id_d = pick_idx;
                    busy_d     = 1'b1;
                    ptr_d      = pick_idx + 2'd1;
                    state_d    = OWN;
`ifdef ARB_TIMEOUT_EN
                    // The first granted cycle counts as cycle 1.
                    hold_cnt_d = 8'd1;
`endif
                end
            end

            OWN: begin
                // Other request bits are deliberately ignored here; only the
                // owner's line decides whether the grant continues.
                if (!req[grant_id_q]) begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q == 8'(MAX_HOLD)) begin
                    // Cycle MAX_HOLD was the last granted one: revoke and
                    // keep this requester out until it drops its request.
                    grant_d            = 4'b0000;
                    busy_d             = 1'b0;
                    state_d            = IDLE;
                    timeout_d          = 1'b1;
                    mask_d[grant_id_q] = 1'b1;
                    hold_cnt_d         = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers with synchronous active-low reset.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            ptr_q      <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            timeout_q  <= 1'b0;
            hold_cnt_q <= 8'd0;
            mask_q     <= 4'b0000;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_arb_rr_4input.sv
// -----------------------------------------------------------------------------
// tb_arb_rr_4input
//
// Directed scenarios followed by randomized request traffic for
// arb_rr_4input. Expected outputs come from a behavioural model that tracks
// the owner as a plain integer and applies the arbitration rules cycle by
// cycle. Build with ARB_TIMEOUT_EN defined to exercise the hold limit
// (MAX_HOLD is then 4).
// -----------------------------------------------------------------------------
module tb_arb_rr_4input;

`ifdef ARB_TIMEOUT_EN
    localparam int MH = 4;
    localparam bit TE = 1'b1;
`else
    localparam int MH = 16;
    localparam bit TE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int m_owner;   // -1 when nobody owns the resource
    int m_ptr;
    int m_gid;
    int m_cnt;     // granted cycles of the current owner so far
    bit m_to;
    bit m_mask [4];

    arb_rr_4input #(.MAX_HOLD(MH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed {grant,id,busy,to}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one rising edge with the given inputs to the model.
    task automatic model_edge(input logic [3:0] r, input logic rst);
        if (!rst) begin
            m_owner = -1; m_ptr = 0; m_gid = 0; m_cnt = 0; m_to = 0;
            for (int i = 0; i < 4; i++) m_mask[i] = 0;
            return;
        end
        m_to = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (TE && m_cnt == MH) begin
                m_to = 1;
                m_mask[m_owner] = 1;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (r[idx] && !m_mask[idx]) begin
                    m_owner = idx;
                    m_gid   = idx;
                    m_ptr   = (idx + 1) % 4;
                    m_cnt   = 1;
                    break;
                end
            end
        end
        for (int i = 0; i < 4; i++)
            if (!r[i]) m_mask[i] = 0;
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_gid), (m_owner >= 0), m_to};
    endfunction

    // Drive inputs at the falling edge, clock once, compare 1 ns later.
    task automatic step(input logic [3:0] r, input logic rst, input string tag);
        @(negedge clk);
        req   = r;
        reset = rst;
        @(posedge clk);
        model_edge(r, rst);
        #1;
        check(tag, {grant, grant_id, busy, timeout}, model_out());
    endtask

    initial begin
        logic [3:0] r;
        req   = 4'b0000;
        reset = 1'b0;

        // Reset for two cycles, then a single request from requester 2.
        step(4'b0000, 1'b0, "reset0");
        step(4'b0000, 1'b0, "reset1");
        step(4'b0100, 1'b1, "first_grant");
        check("first_grant_const", {grant, grant_id, busy}, {4'b0100, 2'd2, 1'b1});
        step(4'b0000, 1'b1, "release2");
        step(4'b0000, 1'b1, "idle");

        // All four requesting; each owner drops for one cycle after 3 cycles.
        step(4'b0000, 1'b0, "rr_reset");
        for (int c = 0; c < 18; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_cnt == 3) r[m_owner] = 1'b0;
            step(r, 1'b1, $sformatf("rr_%0d", c));
        end
        step(4'b0000, 1'b1, "rr_drain");

        // Requester 3 pulses while requester 1 owns the resource.
        step(4'b0000, 1'b0, "ign_reset");
        step(4'b0010, 1'b1, "ign_own1");
        step(4'b1010, 1'b1, "ign_pulse_a");
        step(4'b1010, 1'b1, "ign_pulse_b");
        step(4'b0010, 1'b1, "ign_after_a");
        check("ign_hold_const", {grant, grant_id}, {4'b0010, 2'd1});
        step(4'b0010, 1'b1, "ign_after_b");
        step(4'b0000, 1'b1, "ign_release");
        step(4'b0000, 1'b1, "ign_idle");

        // Reset while requester 0 owns the resource, then regrant.
        step(4'b0000, 1'b0, "rst_own_reset");
        step(4'b0001, 1'b1, "rst_own0");
        step(4'b0001, 1'b1, "rst_own0_hold");
        step(4'b0001, 1'b0, "rst_in_own");
        check("rst_in_own_const", {grant, busy, timeout}, 6'b000000);
        step(4'b0001, 1'b1, "rst_regrant");
        check("rst_regrant_const", {grant, grant_id}, {4'b0001, 2'd0});
        step(4'b0000, 1'b1, "rst_release");

`ifdef ARB_TIMEOUT_EN
        // Hold limit: requester 0 revoked after MH cycles, 1 served next,
        // 0 only competes again after dropping its request.
        step(4'b0000, 1'b0, "to_reset");
        for (int c = 0; c < 12; c++)
            step(4'b0011, 1'b1, $sformatf("to_hold_%0d", c));
        step(4'b0001, 1'b1, "to_drop1");
        step(4'b0001, 1'b1, "to_0_masked");
        check("to_masked_const", grant, 4'b0000);
        step(4'b0000, 1'b1, "to_drop0");
        step(4'b0001, 1'b1, "to_regrant0");
        check("to_regrant_const", grant, 4'b0001);
        step(4'b0000, 1'b1, "to_release");
`else
        // Without the hold limit a held request keeps its grant forever.
        step(4'b0000, 1'b0, "long_reset");
        for (int c = 0; c < 300; c++)
            step(4'b0001, 1'b1, $sformatf("long_%0d", c));
        check("long_const", {grant, timeout}, {4'b0001, 1'b0});
        step(4'b0000, 1'b1, "long_release");
`endif

        // Randomized traffic: bits toggle occasionally, rare resets.
        r = 4'b0000;
        for (int c = 0; c < 2000; c++) begin
            logic rst;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(3) == 0) r[i] = ~r[i];
            rst = ($urandom_range(63) != 0);
            step(r, rst, $sformatf("rand_%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
